fp_align: RTL and testbench

Pre-normalization alignment unit for the single-precision ADD/SUB datapath. It accepts two IEEE-754 binary32 operands and orders them by magnitude. It then right-shifts the smaller significand by the exponent difference, folding shifted-out bits into a sticky bit, and hands the adder an aligned significand pair plus the common exponent. It sits upstream of the adder and of the post-add leading-one normalizer: that normalizer shifts left after the add, this block shifts right before it.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_align_if.sv | 38 +++
 rtl/fp_align_shr_sticky.sv | 39 +++
 rtl/fp_align.sv | 134 +++++++++++++
 tb/tb_fp_align.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared widths, binary32 field slices and operand unpack helper
//            for the FP add/sub pre-normalization alignment unit.
// Revision : 1.0
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 4;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] eff_exp;
        logic [SIG_W-1:0] sig;
    } operand_t;

    // Subnormals share the exponent of the smallest normal, without a hidden bit.
    function automatic operand_t unpack_op(input logic [31:0] x);
        operand_t o;
        logic     hid;
        hid       = |x[EXP_MSB:EXP_LSB];
        o.sign    = x[SIGN_BIT];
        o.eff_exp = hid ? x[EXP_MSB:EXP_LSB] : EXP_W'(1);
        o.sig     = {hid, x[FRAC_MSB:0], 3'b000};
        return o;
    endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_align_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_if
// Brief    : Operand-in / aligned-pair-out valid/ready channels of fp_align.
// Revision : 1.0
// ============================================================================
interface fp_align_if;
    import fp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_big;
    logic [SIG_W-1:0] out_small;
    logic             out_sign_big;
    logic             out_sign_small;
    logic             out_swap;
    logic             out_shift_sat;
    logic             out_special;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_exp, out_big, out_small,
               out_sign_big, out_sign_small, out_swap, out_shift_sat, out_special
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_exp, out_big, out_small,
               out_sign_big, out_sign_small, out_swap, out_shift_sat, out_special
    );

endinterface : fp_align_if
`default_nettype wire

// File: rtl/fp_align_shr_sticky.sv
`default_nettype none
// ============================================================================
// Module   : shr_sticky
// Brief    : Combinational right shifter; shifted-out bits fold into bit 0,
//            shifts of SIG_W or more collapse to a lone sticky bit.
// Revision : 1.0
// ============================================================================
module shr_sticky
    import fp_pkg::*;
(
    input  wire logic [SIG_W-1:0] i_sig,
    input  wire logic [EXP_W-1:0] i_shift,
    output logic      [SIG_W-1:0] o_sig,
    output logic                  o_sat
);

    localparam int               SH_W      = $clog2(SIG_W);
    localparam logic [EXP_W-1:0] c_sig_w_e = EXP_W'(SIG_W);

    logic [SH_W-1:0]  w_sh;
    logic [SIG_W-1:0] w_mask;
    logic [SIG_W-1:0] w_shifted;
    logic             w_lost;

    assign w_sh      = i_shift[SH_W-1:0];
    assign w_mask    = ~({SIG_W{1'b1}} << w_sh);
    assign w_shifted = i_sig >> w_sh;
    assign w_lost    = |(i_sig & w_mask);
    assign o_sat     = (i_shift >= c_sig_w_e);

    always_comb begin
        o_sig = {w_shifted[SIG_W-1:1], w_shifted[0] | w_lost};
        if (o_sat) begin
            o_sig = {{(SIG_W-1){1'b0}}, |i_sig};
        end
    end

endmodule : shr_sticky
`default_nettype wire

// File: rtl/fp_align.sv
`default_nettype none
// ============================================================================
// Module   : fp_align
// Brief    : Two-stage binary32 magnitude ordering and sticky right-alignment
//            of the smaller significand ahead of the single-precision adder.
// Revision : 1.0
// ============================================================================
module fp_align
    import fp_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    fp_align_if.slave  bus
);

    operand_t         w_a;
    operand_t         w_b;
    operand_t         w_big;
    operand_t         w_small;
    logic             w_swap;
    logic             w_special;
    logic [EXP_W-1:0] w_diff;
    logic             w_s2_load;
    logic             w_s1_adv;

    logic             r_s1_valid;
    logic [EXP_W-1:0] r_s1_exp;
    logic [EXP_W-1:0] r_s1_diff;
    logic [SIG_W-1:0] r_s1_big_sig;
    logic [SIG_W-1:0] r_s1_small_sig;
    logic             r_s1_sign_big;
    logic             r_s1_sign_small;
    logic             r_s1_swap;
    logic             r_s1_special;

    logic             r_s2_valid;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SIG_W-1:0] r_s2_big;
    logic [SIG_W-1:0] r_s2_small;
    logic             r_s2_sign_big;
    logic             r_s2_sign_small;
    logic             r_s2_swap;
    logic             r_s2_sat;
    logic             r_s2_special;

    logic [SIG_W-1:0] w_shr_sig;
    logic             w_shr_sat;

    assign w_a = unpack_op(bus.a);
    assign w_b = unpack_op(bus.b);

    // Ordering includes the hidden bit so a subnormal never outranks a normal
    // sharing effective exponent 1.
    assign w_swap    = {w_b.eff_exp, w_b.sig} > {w_a.eff_exp, w_a.sig};
    assign w_big     = w_swap ? w_b : w_a;
    assign w_small   = w_swap ? w_a : w_b;
    assign w_diff    = w_big.eff_exp - w_small.eff_exp;
    assign w_special = (&bus.a[EXP_MSB:EXP_LSB]) | (&bus.b[EXP_MSB:EXP_LSB]);

    assign w_s2_load    = !r_s2_valid | bus.out_ready;
    assign w_s1_adv     = w_s2_load;
    assign bus.in_ready = !r_s1_valid | w_s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid      <= 1'b0;
            r_s1_exp        <= '0;
            r_s1_diff       <= '0;
            r_s1_big_sig    <= '0;
            r_s1_small_sig  <= '0;
            r_s1_sign_big   <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_swap       <= 1'b0;
            r_s1_special    <= 1'b0;
        end else if (bus.in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_exp        <= w_big.eff_exp;
                r_s1_diff       <= w_diff;
                r_s1_big_sig    <= w_big.sig;
                r_s1_small_sig  <= w_small.sig;
                r_s1_sign_big   <= w_big.sign;
                r_s1_sign_small <= w_small.sign;
                r_s1_swap       <= w_swap;
                r_s1_special    <= w_special;
            end
        end
    end

    shr_sticky u_shr (
        .i_sig   (r_s1_small_sig),
        .i_shift (r_s1_diff),
        .o_sig   (w_shr_sig),
        .o_sat   (w_shr_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid      <= 1'b0;
            r_s2_exp        <= '0;
            r_s2_big        <= '0;
            r_s2_small      <= '0;
            r_s2_sign_big   <= 1'b0;
            r_s2_sign_small <= 1'b0;
            r_s2_swap       <= 1'b0;
            r_s2_sat        <= 1'b0;
            r_s2_special    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_exp        <= r_s1_exp;
                r_s2_big        <= r_s1_big_sig;
                r_s2_small      <= w_shr_sig;
                r_s2_sign_big   <= r_s1_sign_big;
                r_s2_sign_small <= r_s1_sign_small;
                r_s2_swap       <= r_s1_swap;
                r_s2_sat        <= w_shr_sat;
                r_s2_special    <= r_s1_special;
            end
        end
    end

    assign bus.out_valid      = r_s2_valid;
    assign bus.out_exp        = r_s2_exp;
    assign bus.out_big        = r_s2_big;
    assign bus.out_small      = r_s2_small;
    assign bus.out_sign_big   = r_s2_sign_big;
    assign bus.out_sign_small = r_s2_sign_small;
    assign bus.out_swap       = r_s2_swap;
    assign bus.out_shift_sat  = r_s2_sat;
    assign bus.out_special    = r_s2_special;

endmodule : fp_align
`default_nettype wire

// File: tb/tb_fp_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_align
// Brief    : Directed self-checking bench for fp_align.
// Revision : 1.0
// ============================================================================
module tb_fp_align;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fp_align_if bus ();

    fp_align dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Full output snapshot: valid, exp, big, small, sign_big, sign_small, swap, sat, special
    function automatic logic [67:0] snap();
        return {bus.out_valid, bus.out_exp, bus.out_big, bus.out_small, bus.out_sign_big,
                bus.out_sign_small, bus.out_swap, bus.out_shift_sat, bus.out_special};
    endfunction

    function automatic logic [67:0] mk(input logic [7:0] e, input logic [26:0] bg,
                                       input logic [26:0] sm, input logic sb, input logic ss,
                                       input logic sw, input logic st, input logic sp);
        return {1'b1, e, bg, sm, sb, ss, sw, st, sp};
    endfunction

    // Entered #1 after a rising edge with out_ready high: accept, then one more edge.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [67:0] expv);
        bus.a        = va;
        bus.b        = vb;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk(tag, snap(), expv);
    endtask

    logic [7:0] got_exp [$];

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", snap(), 68'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", {67'h0, bus.in_ready}, 68'h1);
        chk("idle_no_output", {67'h0, bus.out_valid}, 68'h0);

        run_vec("equal_ones",    32'h3F800000, 32'h3F800000, mk(8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0, 0, 0));
        run_vec("half_vs_one",   32'h3F000000, 32'h3F800000, mk(8'h7F, 27'h4000000, 27'h2000000, 0, 0, 1, 0, 0));
        run_vec("diff24",        32'h4B800000, 32'h3F800000, mk(8'h97, 27'h4000000, 27'h0000004, 0, 0, 0, 0, 0));
        run_vec("diff24_sticky", 32'h4B800000, 32'h3F800001, mk(8'h97, 27'h4000000, 27'h0000005, 0, 0, 0, 0, 0));
        run_vec("diff26",        32'h4C800000, 32'h3F800000, mk(8'h99, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 0));
        run_vec("diff27_sat",    32'h4D000000, 32'h3F800000, mk(8'h9A, 27'h4000000, 27'h0000001, 0, 0, 0, 1, 0));
        run_vec("diff30_sat",    32'h4E800000, 32'h3F800000, mk(8'h9D, 27'h4000000, 27'h0000001, 0, 0, 0, 1, 0));
        run_vec("subnormal",     32'h00000001, 32'h00800000, mk(8'h01, 27'h4000000, 27'h0000008, 0, 0, 1, 0, 0));
        run_vec("signs_swap",    32'hBF800000, 32'h40000000, mk(8'h80, 27'h4000000, 27'h2000000, 0, 1, 1, 0, 0));
        run_vec("equal_mag_sgn", 32'hBF800000, 32'h3F800000, mk(8'h7F, 27'h4000000, 27'h4000000, 1, 0, 0, 0, 0));
        run_vec("inf_special",   32'h7F800000, 32'h3F800000, mk(8'hFF, 27'h4000000, 27'h0000001, 0, 0, 0, 1, 1));
        run_vec("zeros",         32'h00000000, 32'h80000000, mk(8'h01, 27'h0000000, 27'h0000000, 0, 1, 0, 0, 0));

        // Backpressure: three back-to-back pairs, only two fit.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 32'h3F800000; bus.b = 32'h3F800000;
        chk("bp_ready_p1", {67'h0, bus.in_ready}, 68'h1);
        @(posedge clk); #1;
        bus.a = 32'h40000000; bus.b = 32'h3F800000;
        chk("bp_ready_p2", {67'h0, bus.in_ready}, 68'h1);
        @(posedge clk); #1;
        bus.a = 32'h40800000; bus.b = 32'h3F800000;
        chk("bp_ready_full", {67'h0, bus.in_ready}, 68'h0);
        @(posedge clk); #1;
        chk("bp_still_full", {67'h0, bus.in_ready}, 68'h0);
        chk("bp_hold_p1", snap(), mk(8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0, 0, 0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) got_exp.push_back(bus.out_exp);
            @(posedge clk); #1;
            if (i == 0) bus.in_valid = 1'b0;
        end
        chk("bp_count", {36'h0, 32'(got_exp.size())}, 68'd3);
        if (got_exp.size() == 3) begin
            chk("bp_order0", {60'h0, got_exp[0]}, 68'h7F);
            chk("bp_order1", {60'h0, got_exp[1]}, 68'h80);
            chk("bp_order2", {60'h0, got_exp[2]}, 68'h81);
        end

        // Asynchronous reset with both stages occupied.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 32'h40000000; bus.b = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("rst_pre_full", {67'h0, bus.out_valid}, 68'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", snap(), 68'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_ghost", {67'h0, bus.out_valid}, 68'h0);
        end
        bus.a = 32'h3F000000; bus.b = 32'h3F800000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rst_latency_mid", {67'h0, bus.out_valid}, 68'h0);
        @(posedge clk); #1;
        chk("rst_new_pair", snap(), mk(8'h7F, 27'h4000000, 27'h2000000, 0, 0, 1, 0, 0));
        @(posedge clk); #1;
        chk("drain_empty", {67'h0, bus.out_valid}, 68'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fp_align
`default_nettype wire
